// File: rtl/clk_mon_pkg.sv
// Shared types and default configuration for the clk_mon monitored-clock checker.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_MIN_PER  = 8;
  localparam int unsigned DEF_MAX_PER  = 12;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_TIMEOUT  = 64;

endpackage

// File: rtl/clk_mon_sync.sv
// Two-flop synchronizer for the monitored clock plus a rising-edge detector.
// With CLK_MON_DUTY_EN defined the synchronized level is also exported.
module clk_mon_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic mon_i,
  output logic rise_o
`ifdef CLK_MON_DUTY_EN
  ,
  output logic level_o
`endif
);

  logic s1_q, s2_q, d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= mon_i;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign rise_o = s2_q & ~d_q;

`ifdef CLK_MON_DUTY_EN
  assign level_o = s2_q;
`endif

endmodule

// File: rtl/clk_mon.sv
// Measures the period of an asynchronous monitored clock in clk cycles, tracks lock and
// flags fast/slow/stuck conditions. CLK_MON_DUTY_EN adds the hi_o high-time output.
module clk_mon
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MIN_PER  = DEF_MIN_PER,
  parameter int unsigned MAX_PER  = DEF_MAX_PER,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             mon_i,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic             locked_o,
  output logic             err_fast_o,
  output logic             err_slow_o,
  output logic             stuck_o
`ifdef CLK_MON_DUTY_EN
  ,
  output logic [CNT_W-1:0] hi_o
`endif
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_PER);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_PER);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_CNT);

  logic rise;

`ifdef CLK_MON_DUTY_EN
  logic mon_lvl;

  clk_mon_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .mon_i   (mon_i),
    .rise_o  (rise),
    .level_o (mon_lvl)
  );
`else
  clk_mon_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .mon_i  (mon_i),
    .rise_o (rise)
  );
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              vld_q, vld_d;
  logic              locked_q, locked_d;
  logic              fast_q, fast_d;
  logic              slow_q, slow_d;
  logic              stuck_q, stuck_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic [GOOD_W-1:0] good_inc;
  logic              in_window;

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  hi_q, hi_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    period_d = period_q;
    vld_d    = 1'b0;
    locked_d = locked_q;
    // Clear first so a same-cycle set below takes priority.
    fast_d   = fast_q & ~clr_i;
    slow_d   = slow_q & ~clr_i;
    stuck_d  = stuck_q & ~clr_i;

    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    good_inc  = (good_q == LOCK_C) ? good_q : good_q + 1'b1;
    in_window = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);

`ifdef CLK_MON_DUTY_EN
    hi_d = hi_q;
    if (!en_i) begin
      hi_cnt_d = '0;
    end else if (rise) begin
      hi_cnt_d = CNT_ONE;
    end else if (mon_lvl && hi_cnt_q != CNT_MAX) begin
      hi_cnt_d = hi_cnt_q + 1'b1;
    end else begin
      hi_cnt_d = hi_cnt_q;
    end
`endif

    if (!en_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end else if (cnt_q != TIMEOUT_C) begin
            // Fires only on the transition so a clr_i while parked here sticks.
            cnt_d = cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              stuck_d = 1'b1;
            end
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            cnt_d    = CNT_ONE;
            period_d = cnt_q;
            vld_d    = 1'b1;
`ifdef CLK_MON_DUTY_EN
            hi_d     = hi_cnt_q;
`endif
            if (in_window) begin
              good_d = good_inc;
              if (good_inc == LOCK_C) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              good_d   = '0;
              state_d  = MEASURE;
              locked_d = 1'b0;
              if (cnt_q < MIN_C) begin
                fast_d = 1'b1;
              end else begin
                slow_d = 1'b1;
              end
            end
          end else if (cnt_q == TIMEOUT_C) begin
            // cnt stays at TIMEOUT so IDLE does not re-flag the same outage.
            stuck_d  = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      fast_q   <= 1'b0;
      slow_q   <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      fast_q   <= fast_d;
      slow_q   <= slow_d;
      stuck_q  <= stuck_d;
    end
  end

`ifdef CLK_MON_DUTY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt_q <= '0;
      hi_q     <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      hi_q     <= hi_d;
    end
  end

  assign hi_o = hi_q;
`endif

  assign period_o     = period_q;
  assign period_vld_o = vld_q;
  assign locked_o     = locked_q;
  assign err_fast_o   = fast_q;
  assign err_slow_o   = slow_q;
  assign stuck_o      = stuck_q;

endmodule
